// File: rtl/reg_native_if_pkg.sv
// Shared types for the reg_native_if forwarding path: responder FSM states,
// default error read data and the request record used by bench monitors.
package reg_native_if_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hdeadbeef;

    // Request record at the default bus widths (64-bit address, 32-bit data).
    typedef struct packed {
        logic [63:0] addr;
        logic        wr_en;
        logic        rd_en;
        logic [31:0] wr_data;
    } req_t;

endpackage

// File: rtl/reg_native_if_responder_if.sv
// Request/ack bundle between a reg_native_if forwarder (master) and the
// responding register IP (slave).
interface reg_native_if_responder_if #(
    parameter int unsigned BUS_DATA_WIDTH = 32,
    parameter int unsigned BUS_ADDR_WIDTH = 64
);
    logic                      ext_req_vld;
    logic [BUS_ADDR_WIDTH-1:0] ext_addr;
    logic                      ext_wr_en;
    logic                      ext_rd_en;
    logic [BUS_DATA_WIDTH-1:0] ext_wr_data;
    logic                      ext_ack_vld;
    logic [BUS_DATA_WIDTH-1:0] ext_rd_data;

    modport master (
        output ext_req_vld, ext_addr, ext_wr_en, ext_rd_en, ext_wr_data,
        input  ext_ack_vld, ext_rd_data
    );

    modport slave (
        input  ext_req_vld, ext_addr, ext_wr_en, ext_rd_en, ext_wr_data,
        output ext_ack_vld, ext_rd_data
    );
endinterface

// File: rtl/reg_native_if_decoder.sv
// Combinational byte-address decoder: maps an address onto a register index
// of a word-strided bank starting at BASE_ADDR.
module reg_native_if_decoder #(
    parameter int unsigned BUS_DATA_WIDTH = 32,
    parameter int unsigned BUS_ADDR_WIDTH = 64,
    parameter int unsigned REG_NUM = 16,
    parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    localparam int unsigned IDX_WIDTH = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
    input  logic [BUS_ADDR_WIDTH-1:0] addr,
    output logic                      hit,
    output logic [IDX_WIDTH-1:0]      index
);
    localparam int unsigned STRIDE = BUS_DATA_WIDTH / 8;
    // One extra bit so a bank ending exactly at the top of the address space fits.
    localparam logic [BUS_ADDR_WIDTH:0] SPAN = (BUS_ADDR_WIDTH + 1)'(REG_NUM * STRIDE);
    localparam logic [BUS_ADDR_WIDTH-1:0] STRIDE_A = BUS_ADDR_WIDTH'(STRIDE);

    logic [BUS_ADDR_WIDTH-1:0] offset;

    always_comb begin
        offset = addr - BASE_ADDR;
        hit    = (addr >= BASE_ADDR) && ({1'b0, offset} < SPAN)
                 && ((offset % STRIDE_A) == '0);
        index  = IDX_WIDTH'(offset / STRIDE_A);
    end

endmodule

// File: rtl/reg_native_if_responder.sv
// Register-bank responder for the far end of reg_native_if: accepts one request
// at a time and acks it a fixed ACK_LATENCY cycles later.
module reg_native_if_responder
    import reg_native_if_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = 32,
    parameter int unsigned BUS_ADDR_WIDTH = 64,
    parameter int unsigned REG_NUM = 16,
    parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned ACK_LATENCY = 2,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                              ext_clk,
    input  logic                              ext_rst,
    reg_native_if_responder_if.slave          bus,
    output logic [REG_NUM*BUS_DATA_WIDTH-1:0] reg_q,
    output logic                              req_overrun
);
    localparam int unsigned IDX_WIDTH = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam int unsigned CNT_WIDTH = (ACK_LATENCY > 2) ? $clog2(ACK_LATENCY - 1) : 1;
    localparam bit DIRECT_ACK = (ACK_LATENCY == 1);
    localparam logic [BUS_DATA_WIDTH-1:0] ERR_DATA_W = BUS_DATA_WIDTH'(ERR_DATA);

    state_e                                   state_q;
    logic [CNT_WIDTH-1:0]                     cnt_q;
    logic [BUS_ADDR_WIDTH-1:0]                addr_q;
    logic                                     wr_en_q;
    logic                                     rd_en_q;
    logic [BUS_DATA_WIDTH-1:0]                wr_data_q;
    logic                                     ack_vld_q;
    logic [BUS_DATA_WIDTH-1:0]                rd_data_q;
    logic [REG_NUM-1:0][BUS_DATA_WIDTH-1:0]   regs_q;
    logic                                     overrun_q;

    logic                      accept;
    logic                      finish;
    logic [BUS_ADDR_WIDTH-1:0] fin_addr;
    logic                      fin_wr;
    logic                      fin_rd;
    logic [BUS_DATA_WIDTH-1:0] fin_data;
    logic                      hit;
    logic [IDX_WIDTH-1:0]      idx;

    // With latency 1 the request completes on the edge that accepts it, so the
    // live bus is decoded; otherwise the captured copy is.
    always_comb begin
        accept = bus.ext_req_vld && (state_q != StWait);
        if (DIRECT_ACK) begin
            fin_addr = bus.ext_addr;
            fin_wr   = bus.ext_wr_en;
            fin_rd   = bus.ext_rd_en;
            fin_data = bus.ext_wr_data;
            finish   = accept;
        end else begin
            fin_addr = addr_q;
            fin_wr   = wr_en_q;
            fin_rd   = rd_en_q;
            fin_data = wr_data_q;
            finish   = (state_q == StWait) && (cnt_q == '0);
        end
    end

    reg_native_if_decoder #(
        .BUS_DATA_WIDTH (BUS_DATA_WIDTH),
        .BUS_ADDR_WIDTH (BUS_ADDR_WIDTH),
        .REG_NUM        (REG_NUM),
        .BASE_ADDR      (BASE_ADDR)
    ) u_decoder (
        .addr  (fin_addr),
        .hit   (hit),
        .index (idx)
    );

    always_ff @(posedge ext_clk or posedge ext_rst) begin
        if (ext_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_data_q <= '0;
            ack_vld_q <= 1'b0;
            rd_data_q <= '0;
            regs_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            ack_vld_q <= finish;
            rd_data_q <= '0;
            if (finish) begin
                if (fin_wr) begin
                    if (hit) begin
                        regs_q[idx] <= fin_data;
                    end
                end else if (fin_rd) begin
                    rd_data_q <= hit ? regs_q[idx] : ERR_DATA_W;
                end
            end

            if (accept) begin
                addr_q    <= bus.ext_addr;
                wr_en_q   <= bus.ext_wr_en;
                rd_en_q   <= bus.ext_rd_en;
                wr_data_q <= bus.ext_wr_data;
            end

            case (state_q)
                StIdle, StAck: begin
                    if (!accept) begin
                        state_q <= StIdle;
                    end else if (DIRECT_ACK) begin
                        state_q <= StAck;
                    end else begin
                        state_q <= StWait;
                        cnt_q   <= CNT_WIDTH'(ACK_LATENCY - 2);
                    end
                end
                StWait: begin
                    if (bus.ext_req_vld) begin
                        overrun_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_q <= StAck;
                    end else begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ext_ack_vld = ack_vld_q;
    assign bus.ext_rd_data = rd_data_q;
    assign reg_q           = regs_q;
    assign req_overrun     = overrun_q;

endmodule

// File: tb/tb_reg_native_if_responder.sv
// Bench: three responders (ack latency 1, 2, 5) share one request stream and are
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_reg_native_if_responder;
    import reg_native_if_pkg::*;

    localparam int unsigned W    = 32;
    localparam int unsigned AW   = 64;
    localparam int unsigned NREG = 16;
    localparam logic [63:0] BASE = 64'h1000;
    localparam int NINST = 3;
    localparam int LAT [NINST] = '{1, 2, 5};

    logic        clk;
    logic        rst;
    logic        req_vld;
    logic [63:0] addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wr_data;

    logic [NINST-1:0] ack_w;
    logic [NINST-1:0] ovr_w;
    logic [31:0]      rd_w   [NINST];
    logic [511:0]     regq_w [NINST];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < NINST; k++) begin : g_dut
        reg_native_if_responder_if #(.BUS_DATA_WIDTH(W), .BUS_ADDR_WIDTH(AW)) bus ();

        assign bus.ext_req_vld = req_vld;
        assign bus.ext_addr    = addr;
        assign bus.ext_wr_en   = wr_en;
        assign bus.ext_rd_en   = rd_en;
        assign bus.ext_wr_data = wr_data;
        assign ack_w[k]        = bus.ext_ack_vld;
        assign rd_w[k]         = bus.ext_rd_data;

        reg_native_if_responder #(
            .BUS_DATA_WIDTH (W),
            .BUS_ADDR_WIDTH (AW),
            .REG_NUM        (NREG),
            .BASE_ADDR      (BASE),
            .ACK_LATENCY    (LAT[k]),
            .ERR_DATA       (32'hdeadbeef)
        ) u_dut (
            .ext_clk     (clk),
            .ext_rst     (rst),
            .bus         (bus),
            .reg_q       (regq_w[k]),
            .req_overrun (ovr_w[k])
        );
    end

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] m_regs [NINST][NREG];
    bit          m_busy [NINST];
    longint      m_due  [NINST];
    req_t        m_req  [NINST];
    bit          m_ovr  [NINST];
    bit          m_ack  [NINST];
    logic [31:0] m_rd   [NINST];
    longint      cyc = 0;

    function automatic int decode(input logic [63:0] a);
        if (a < BASE || a >= BASE + 64'(NREG * 4) || (a % 4) != 0) return -1;
        return int'((a - BASE) / 4);
    endfunction

    initial begin
        logic        s_rst, s_vld, s_wr, s_rd;
        logic [63:0] s_addr;
        logic [31:0] s_data;
        logic [511:0] ev;
        int          ix;
        forever begin
            @(posedge clk);
            s_rst = rst; s_vld = req_vld; s_addr = addr;
            s_wr = wr_en; s_rd = rd_en; s_data = wr_data;
            #1;
            for (int k = 0; k < NINST; k++) begin
                if (s_rst) begin
                    m_busy[k] = 0;
                    m_ovr[k]  = 0;
                    for (int j = 0; j < NREG; j++) m_regs[k][j] = '0;
                end else if (s_vld) begin
                    if (!m_busy[k]) begin
                        m_busy[k] = 1;
                        m_due[k]  = cyc + longint'(LAT[k]);
                        m_req[k]  = '{addr: s_addr, wr_en: s_wr, rd_en: s_rd, wr_data: s_data};
                    end else begin
                        m_ovr[k] = 1;
                    end
                end
            end
            cyc++;
            for (int k = 0; k < NINST; k++) begin
                m_ack[k] = 0;
                m_rd[k]  = '0;
                if (m_busy[k] && m_due[k] == cyc) begin
                    m_ack[k]  = 1;
                    m_busy[k] = 0;
                    ix = decode(m_req[k].addr);
                    if (m_req[k].wr_en) begin
                        if (ix >= 0) m_regs[k][ix] = m_req[k].wr_data;
                    end else if (m_req[k].rd_en) begin
                        m_rd[k] = (ix >= 0) ? m_regs[k][ix] : 32'hdeadbeef;
                    end
                end
                ev = '0;
                for (int j = 0; j < NREG; j++) ev[j*32 +: 32] = m_regs[k][j];
                chk($sformatf("ack L%0d cyc %0d", LAT[k], cyc), ack_w[k], m_ack[k]);
                chk($sformatf("rd_data L%0d cyc %0d", LAT[k], cyc), rd_w[k], m_rd[k]);
                chk($sformatf("reg_q L%0d cyc %0d", LAT[k], cyc), regq_w[k], ev);
                chk($sformatf("overrun L%0d cyc %0d", LAT[k], cyc), ovr_w[k], m_ovr[k]);
            end
        end
    end

    // ---------------- stimulus with literal expectations ----------------
    task automatic drive(input logic [63:0] a, input logic w, input logic r, input logic [31:0] d);
        req_vld = 1'b1; addr = a; wr_en = w; rd_en = r; wr_data = d;
    endtask

    task automatic step();
        @(negedge clk);
        req_vld = 1'b0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    endtask

    // Issue one request from idle and pin the ack cycle of every latency.
    task automatic txn(input logic [63:0] a, input logic w, input logic r,
                       input logic [31:0] d, input logic [31:0] e);
        drive(a, w, r, d);
        step();
        chk("lit L1 ack", ack_w[0], 1'b1);
        chk("lit L1 rd", rd_w[0], e);
        chk("lit L2 ack early", ack_w[1], 1'b0);
        step();
        chk("lit L2 ack", ack_w[1], 1'b1);
        chk("lit L2 rd", rd_w[1], e);
        chk("lit L1 single ack", ack_w[0], 1'b0);
        step();
        step();
        chk("lit L5 ack early", ack_w[2], 1'b0);
        step();
        chk("lit L5 ack", ack_w[2], 1'b1);
        chk("lit L5 rd", rd_w[2], e);
        step();
    endtask

    initial begin
        logic [511:0] ev;
        logic [63:0]  a;
        int           ri;
        rst = 1'b1; req_vld = 1'b0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset ack", ack_w, '0);
        chk("reset rd", rd_w[1], '0);
        chk("reset reg_q", regq_w[1], '0);
        chk("reset overrun", ovr_w, '0);

        // write hit, then read it back
        txn(64'h1008, 1'b1, 1'b0, 32'ha5a5_0001, 32'h0);
        chk("lit reg2 after write", regq_w[1][2*32 +: 32], 32'ha5a5_0001);
        txn(64'h1008, 1'b0, 1'b1, 32'h0, 32'ha5a5_0001);

        // misses: below base, past end, misaligned
        txn(64'h0ffc, 1'b0, 1'b1, 32'h0, 32'hdeadbeef);
        txn(64'h1040, 1'b0, 1'b1, 32'h0, 32'hdeadbeef);
        txn(64'h1002, 1'b0, 1'b1, 32'h0, 32'hdeadbeef);
        txn(64'h1040, 1'b1, 1'b0, 32'h5555_5555, 32'h0);
        ev = '0;
        ev[2*32 +: 32] = 32'ha5a5_0001;
        chk("lit reg_q after miss write", regq_w[1], ev);

        // write+read together is a write; no enables is a no-op
        txn(64'h1000, 1'b1, 1'b1, 32'h0000_1234, 32'h0);
        chk("lit reg0 wr+rd", regq_w[1][31:0], 32'h0000_1234);
        txn(64'h1004, 1'b0, 1'b0, 32'hffff_ffff, 32'h0);
        chk("lit reg1 untouched", regq_w[1][1*32 +: 32], 32'h0);

        // back-to-back: second request in the ack cycle of the first
        drive(64'h1000, 1'b0, 1'b1, 32'h0);
        step();
        step();
        chk("lit b2b first ack", ack_w[1], 1'b1);
        chk("lit b2b first rd", rd_w[1], 32'h0000_1234);
        drive(64'h1008, 1'b0, 1'b1, 32'h0);
        step();
        chk("lit b2b gap", ack_w[1], 1'b0);
        step();
        chk("lit b2b second ack", ack_w[1], 1'b1);
        chk("lit b2b second rd", rd_w[1], 32'ha5a5_0001);
        chk("lit b2b no overrun", ovr_w[1], 1'b0);
        repeat (6) step();

        // request during WAIT is dropped and flagged
        drive(64'h1000, 1'b0, 1'b1, 32'h0);
        step();
        drive(64'h1008, 1'b0, 1'b1, 32'h0);
        step();
        chk("lit ovr ack", ack_w[1], 1'b1);
        chk("lit ovr rd", rd_w[1], 32'h0000_1234);
        step();
        chk("lit ovr no extra ack a", ack_w[1], 1'b0);
        step();
        chk("lit ovr no extra ack b", ack_w[1], 1'b0);
        repeat (6) step();
        chk("lit ovr sticky", ovr_w[1], 1'b1);

        // latency 1 with requests on consecutive cycles
        drive(64'h1000, 1'b0, 1'b1, 32'h0);
        step();
        chk("lit L1 burst ack0", ack_w[0], 1'b1);
        chk("lit L1 burst rd0", rd_w[0], 32'h0000_1234);
        drive(64'h1008, 1'b0, 1'b1, 32'h0);
        step();
        chk("lit L1 burst ack1", ack_w[0], 1'b1);
        chk("lit L1 burst rd1", rd_w[0], 32'ha5a5_0001);
        drive(64'h0ffc, 1'b0, 1'b1, 32'h0);
        step();
        chk("lit L1 burst ack2", ack_w[0], 1'b1);
        chk("lit L1 burst rd2", rd_w[0], 32'hdeadbeef);
        step();
        chk("lit L1 burst done", ack_w[0], 1'b0);
        repeat (6) step();

        // reset during WAIT of a write discards it
        drive(64'h1004, 1'b1, 1'b0, 32'h0000_0077);
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("lit no ack after reset", ack_w[1], 1'b0);
        end
        chk("lit reg_q after reset", regq_w[1], '0);
        chk("lit overrun after reset", ovr_w, '0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 399) == 0);
            req_vld = ($urandom_range(0, 99) < 45);
            {wr_en, rd_en} = 2'($urandom_range(0, 3));
            wr_data = $urandom;
            ri = $urandom_range(0, 15);
            case ($urandom_range(0, 5))
                0, 1, 2: a = BASE + 64'(ri * 4);
                3:       a = BASE + 64'(ri * 4) + 64'($urandom_range(1, 3));
                4:       a = BASE - 64'($urandom_range(1, 4) * 4);
                default: a = BASE + 64'(NREG * 4) + 64'($urandom_range(0, 8) * 4);
            endcase
            addr = a;
        end
        step();
        rst = 1'b0;
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
